// File: rtl/mix_arbiter.sv
// Round-robin arbiter that shares one Mix128 datapath between two requesters.
// Captures operands, sequences mix_reset/mix_en, returns results, aborts on watchdog.
module mix_arbiter #(
    parameter int CWIDTH   = 320,
    parameter int XWORDS32 = 4,
    parameter int DS_WIDTH = 128,
    parameter int TIMEOUT  = 4096
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [XWORDS32*32-1:0] x,
    input  logic                   req0,
    input  logic                   req1,
    input  logic [CWIDTH-1:0]      c0,
    input  logic [CWIDTH-1:0]      c1,
    input  logic [127:0]           i0,
    input  logic [127:0]           i1,
    input  logic [DS_WIDTH-1:0]    ds0,
    input  logic [DS_WIDTH-1:0]    ds1,
    output logic                   gnt0,
    output logic                   gnt1,
    output logic                   rsp_valid0,
    output logic                   rsp_valid1,
    output logic                   rsp_err0,
    output logic                   rsp_err1,
    output logic [CWIDTH-1:0]      rsp_c,
    output logic                   mix_reset,
    output logic                   mix_en,
    output logic [CWIDTH-1:0]      mix_c,
    output logic [127:0]           mix_i,
    output logic [DS_WIDTH-1:0]    mix_ds,
    output logic [XWORDS32*32-1:0] mix_x,
    input  logic [CWIDTH-1:0]      mix_cout,
    input  logic                   mix_done,
    output logic                   busy
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WLIM = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t            state, state_n;
    logic              owner, owner_n;
    logic              last, last_n;
    logic              winner;
    logic              cap;
    logic [WW-1:0]     wdog, wdog_n;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rv_q, rv_d;
    logic [1:0]        re_q, re_d;
    logic [CWIDTH-1:0] rsp_c_d;
    logic              mr_d, me_d, busy_d;

    assign mix_x      = x;
    assign gnt0       = gnt_q[0];
    assign gnt1       = gnt_q[1];
    assign rsp_valid0 = rv_q[0];
    assign rsp_valid1 = rv_q[1];
    assign rsp_err0   = re_q[0];
    assign rsp_err1   = re_q[1];

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        wdog_n  = wdog;
        rsp_c_d = rsp_c;
        cap     = 1'b0;
        gnt_d   = 2'b00;
        rv_d    = 2'b00;
        re_d    = 2'b00;
        mr_d    = 1'b1;
        me_d    = 1'b0;
        busy_d  = 1'b0;
        winner  = (req0 & req1) ? ~last : req1;
        unique case (state)
            IDLE: begin
                if (req0 | req1) begin
                    state_n       = RUN;
                    owner_n       = winner;
                    last_n        = winner;
                    wdog_n        = '0;
                    cap           = 1'b1;
                    gnt_d[winner] = 1'b1;
                    mr_d          = 1'b0;
                    me_d          = 1'b1;
                    busy_d        = 1'b1;
                end
            end
            RUN: begin
                wdog_n = wdog + 1'b1;
                busy_d = 1'b1;
                if (mix_done) begin
                    state_n     = RESP;
                    rsp_c_d     = mix_cout;
                    rv_d[owner] = 1'b1;
                end else if (wdog == WLIM) begin
                    state_n     = RESP;
                    rsp_c_d     = '0;
                    rv_d[owner] = 1'b1;
                    re_d[owner] = 1'b1;
                end else begin
                    mr_d = 1'b0;
                    me_d = 1'b1;
                end
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            wdog      <= '0;
            gnt_q     <= 2'b00;
            rv_q      <= 2'b00;
            re_q      <= 2'b00;
            rsp_c     <= '0;
            mix_reset <= 1'b1;
            mix_en    <= 1'b0;
            busy      <= 1'b0;
            mix_c     <= '0;
            mix_i     <= '0;
            mix_ds    <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            last      <= last_n;
            wdog      <= wdog_n;
            gnt_q     <= gnt_d;
            rv_q      <= rv_d;
            re_q      <= re_d;
            rsp_c     <= rsp_c_d;
            mix_reset <= mr_d;
            mix_en    <= me_d;
            busy      <= busy_d;
            if (cap) begin
                mix_c  <= winner ? c1 : c0;
                mix_i  <= winner ? i1 : i0;
                mix_ds <= winner ? ds1 : ds0;
            end
        end
    end

endmodule

// File: tb/tb_mix_arbiter.sv
// Bench for mix_arbiter: stub Mix128, schedule-based job model, directed scenarios.
// The model predicts each job's grant cycle, run length and response from the rules.
module tb_mix_arbiter;
    localparam int CW  = 320;
    localparam int XW  = 4;
    localparam int DSW = 128;
    localparam int T   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n = 1'b1;
    logic [XW*32-1:0] x;
    logic           req0, req1;
    logic [CW-1:0]  c0, c1;
    logic [127:0]   i0, i1;
    logic [DSW-1:0] ds0, ds1;
    logic           gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1;
    logic [CW-1:0]  rsp_c, mix_c, mix_cout;
    logic [127:0]   mix_i;
    logic [DSW-1:0] mix_ds;
    logic [XW*32-1:0] mix_x;
    logic           mix_reset, mix_en, mix_done, busy;

    int n_cmp = 0;
    int n_err = 0;

    int            stub_lat  = 3;
    bit            stub_hang = 1'b0;
    logic [CW-1:0] stub_cout = '0;
    logic [15:0]   scnt;

    mix_arbiter #(.CWIDTH(CW), .XWORDS32(XW), .DS_WIDTH(DSW), .TIMEOUT(T)) dut (
        .clk(clk), .reset_n(reset_n), .x(x),
        .req0(req0), .req1(req1),
        .c0(c0), .c1(c1), .i0(i0), .i1(i1), .ds0(ds0), .ds1(ds1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_err0(rsp_err0), .rsp_err1(rsp_err1),
        .rsp_c(rsp_c), .mix_reset(mix_reset), .mix_en(mix_en),
        .mix_c(mix_c), .mix_i(mix_i), .mix_ds(mix_ds), .mix_x(mix_x),
        .mix_cout(mix_cout), .mix_done(mix_done), .busy(busy)
    );

    // Stub Mix128: done rises stub_lat enabled cycles after leaving reset.
    always @(posedge clk) begin
        if (mix_reset) begin
            scnt     <= '0;
            mix_done <= 1'b0;
            mix_cout <= '0;
        end else if (mix_en && !mix_done) begin
            scnt <= scnt + 16'd1;
            if (!stub_hang && int'(scnt) == stub_lat - 1) begin
                mix_done <= 1'b1;
                mix_cout <= mix_c ^ stub_cout;
            end
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Job-schedule model: one job at a time, described by start cycle and length.
    int            cyc, idle_from, js, jr;
    bit            have_job, jown, jerr, mlast, w;
    logic [CW-1:0] jc, jc_res, prev_rsp;
    logic [127:0]  ji;
    logic [DSW-1:0] jds;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            cyc = 0; idle_from = 0; have_job = 0; mlast = 1; prev_rsp = '0;
        end else begin
            if (cyc >= idle_from && (req0 || req1)) begin
                w = (req0 && req1) ? !mlast : req1;
                if (have_job) prev_rsp = jc_res;
                have_job = 1; jown = w; mlast = w; js = cyc + 1;
                jc  = w ? c1 : c0;
                ji  = w ? i1 : i0;
                jds = w ? ds1 : ds0;
                if (!stub_hang && stub_lat <= T - 1) begin
                    jr = stub_lat + 1; jerr = 0; jc_res = jc ^ stub_cout;
                end else begin
                    jr = T; jerr = 1; jc_res = '0;
                end
                idle_from = js + jr + 1;
            end
            cyc++;
        end
    end

    int gq[$];
    bit e_run, e_resp, e_gnt;
    logic [CW-1:0] e_rc;

    initial forever begin
        @(negedge clk);
        if (gnt0) gq.push_back(0);
        if (gnt1) gq.push_back(1);
        if (!reset_n) begin
            e_run = 0; e_resp = 0; e_gnt = 0; e_rc = '0;
        end else begin
            e_run  = have_job && cyc >= js && cyc < js + jr;
            e_resp = have_job && cyc == js + jr;
            e_gnt  = have_job && cyc == js;
            e_rc   = (have_job && cyc >= js + jr) ? jc_res : prev_rsp;
        end
        chk1("gnt0", gnt0, e_gnt && !jown);
        chk1("gnt1", gnt1, e_gnt && jown);
        chk1("rsp_valid0", rsp_valid0, e_resp && !jown);
        chk1("rsp_valid1", rsp_valid1, e_resp && jown);
        chk1("rsp_err0", rsp_err0, e_resp && !jown && jerr);
        chk1("rsp_err1", rsp_err1, e_resp && jown && jerr);
        chk1("mix_reset", mix_reset, !e_run);
        chk1("mix_en", mix_en, e_run);
        chk1("busy", busy, e_run || e_resp);
        chkw("rsp_c", rsp_c, e_rc);
        chkw("mix_c", mix_c, (reset_n && have_job) ? jc : '0);
        chkw("mix_i", CW'(mix_i), (reset_n && have_job) ? CW'(ji) : '0);
        chkw("mix_ds", CW'(mix_ds), (reset_n && have_job) ? CW'(jds) : '0);
        chkw("mix_x", CW'(mix_x), CW'(x));
    end

    task automatic wait_gnt(output int k);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(gnt0 || gnt1) && n < 100);
        k = gnt1 ? 1 : 0;
        if (n >= 100) chki("wait_gnt_timeout", n, 0);
    endtask

    task automatic wait_valid(output int k, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!(rsp_valid0 || rsp_valid1) && n < 100);
        k = rsp_valid1 ? 1 : 0;
        if (n >= 100) chki("wait_valid_timeout", n, 0);
    endtask

    task automatic do_reset;
        reset_n = 0; req0 = 0; req1 = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
    endtask

    int k, n, ec, code;

    initial begin
        x   = 128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978;
        c0  = 320'h1234;  i0 = 128'hA5;  ds0 = 128'h11;
        c1  = 320'hCAFE_0000_0000_0000_5555;  i1 = 128'h77;  ds1 = 128'h22;
        req0 = 0; req1 = 0;
        #1 reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_mix_reset", mix_reset, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mix_en", mix_en, 1'b0);
        chkw("rst_rsp_c", rsp_c, '0);
        reset_n = 1;

        // single job from requester 0
        stub_lat = 10; stub_cout = 320'hBEEF ^ 320'h1234; req0 = 1;
        @(negedge clk);
        chk1("t1_pre_gnt0", gnt0, 1'b0);
        @(negedge clk);
        chk1("t1_gnt0", gnt0, 1'b1);
        chk1("t1_mix_reset", mix_reset, 1'b0);
        chk1("t1_mix_en", mix_en, 1'b1);
        req0 = 0;
        wait_valid(k, n);
        chki("t1_owner", k, 0);
        chki("t1_latency", n, 11);
        chk1("t1_err0", rsp_err0, 1'b0);
        chkw("t1_rsp_c", rsp_c, 320'hBEEF);
        @(negedge clk);
        chk1("t1_idle_busy", busy, 1'b0);
        chkw("t1_rsp_hold", rsp_c, 320'hBEEF);

        // simultaneous requests after reset
        do_reset; gq.delete(); stub_lat = 2; stub_cout = 320'h3C;
        req0 = 1; req1 = 1;
        wait_valid(k, n); chki("t2_first", k, 0); req0 = 0;
        wait_valid(k, n); chki("t2_second", k, 1);
        chk1("t2_no_rv0", rsp_valid0, 1'b0); req1 = 0;
        repeat (2) @(negedge clk);
        code = (gq.size() == 2) ? gq[0] * 10 + gq[1] : -1;
        chki("t2_grant_order", code, 1);

        // fairness with both requests held
        do_reset; gq.delete(); stub_lat = 3; req0 = 1; req1 = 1;
        for (int j = 0; j < 6; j++) begin
            wait_valid(k, n);
            chki("t3_owner", k, j % 2);
            if (j == 5) begin req0 = 0; req1 = 0; end
            @(negedge clk);
            chk1("t3_gap_reset", mix_reset, 1'b1);
            chk1("t3_gap_busy", busy, 1'b0);
        end
        code = 0;
        foreach (gq[q]) code = code * 2 + gq[q];
        chki("t3_grant_count", gq.size(), 6);
        chki("t3_grant_order", code, 21);

        // watchdog abort, done exactly at the limit, and one cycle past it
        do_reset; stub_hang = 1; req1 = 1;
        wait_gnt(k); chki("t4_gnt", k, 1); req1 = 0;
        ec = 0; n = 0;
        do begin
            if (mix_en) ec++;
            @(negedge clk); n++;
        end while (!(rsp_valid0 || rsp_valid1) && n < 100);
        chki("t4_run_len", ec, 16);
        chk1("t4_rv1", rsp_valid1, 1'b1);
        chk1("t4_err1", rsp_err1, 1'b1);
        chkw("t4_rsp_c", rsp_c, '0);
        stub_hang = 0; stub_cout = 320'h5A; stub_lat = 15; req1 = 1;
        wait_gnt(k); req1 = 0;
        wait_valid(k, n);
        chki("t4_edge_len", n, 16);
        chk1("t4_edge_err", rsp_err1, 1'b0);
        chkw("t4_edge_c", rsp_c, c1 ^ 320'h5A);
        stub_lat = 16; req1 = 1;
        wait_gnt(k); req1 = 0;
        wait_valid(k, n);
        chki("t4_over_len", n, 16);
        chk1("t4_over_err", rsp_err1, 1'b1);
        stub_lat = 4; req0 = 1;
        wait_gnt(k); chki("t4_next_gnt", k, 0); req0 = 0;
        wait_valid(k, n);
        chk1("t4_next_err", rsp_err0, 1'b0);
        chkw("t4_next_c", rsp_c, c0 ^ 320'h5A);

        // reset in the middle of a run
        do_reset; stub_lat = 20; req1 = 1;
        wait_gnt(k);
        repeat (4) @(negedge clk);
        #2 reset_n = 0;
        #1;
        chk1("t5_mix_reset", mix_reset, 1'b1);
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_mix_en", mix_en, 1'b0);
        chk1("t5_gnt1", gnt1, 1'b0);
        req0 = 1;
        @(posedge clk);
        #1 reset_n = 1;
        stub_lat = 3;
        wait_gnt(k); chki("t5_first_after_rst", k, 0); req0 = 0;
        wait_valid(k, n); chki("t5_rsp_owner", k, 0);
        wait_valid(k, n); chki("t5_second_owner", k, 1); req1 = 0;

        // req0 toggling while requester 1 runs is ignored
        @(negedge clk);
        gq.delete(); c1 = 320'hF00D_0000_1111; stub_lat = 6; req1 = 1;
        wait_gnt(k); chki("t6_gnt", k, 1); req1 = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk); req0 = ~req0;
        end
        req0 = 0;
        wait_valid(k, n);
        chki("t6_owner", k, 1);
        chkw("t6_rsp_c", rsp_c, 320'hF00D_0000_1111 ^ 320'h5A);
        repeat (2) @(negedge clk);
        chki("t6_grants", gq.size(), 1);
        chk1("t6_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL global_timeout: got running want finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "global timeout");
    end

endmodule
